// File: rtl/bexkat1_intseq_pkg.sv
// Shared bexkat1 definitions: INT-class function codes, operand-B select and
// the sequencer state type visible to the control unit and bench.
package bexkat1Def;

  localparam int INT_WIDTH = 32;
  localparam int REG_SP    = 15;

  typedef enum logic [3:0] {
    INT_MUL   = 4'd0,
    INT_DIV   = 4'd1,
    INT_MOD   = 4'd2,
    INT_MULU  = 4'd3,
    INT_DIVU  = 4'd4,
    INT_MODU  = 4'd5,
    INT_MULX  = 4'd6,
    INT_MULUX = 4'd7,
    INT_EXT   = 4'd8,
    INT_EXTB  = 4'd9,
    INT_COM   = 4'd10,
    INT_NEG   = 4'd11
  } intfunc_t;

  typedef enum logic {
    INT2_B    = 1'b0,
    INT2_SVAL = 1'b1
  } int2_t;

  typedef enum logic [1:0] {
    IS_IDLE = 2'd0,
    IS_MUL  = 2'd1,
    IS_DIV  = 2'd2,
    IS_DONE = 2'd3
  } intseq_state_t;

  // Result of every operation that finishes in one step, including the
  // divide-by-zero fallbacks; unused codes yield zero.
  function automatic logic [INT_WIDTH-1:0] immediate_result(intfunc_t f,
                                                            logic [INT_WIDTH-1:0] a);
    logic [INT_WIDTH-1:0] r;
    r = '0;
    case (f)
      INT_EXT:           r = {{(INT_WIDTH-16){a[15]}}, a[15:0]};
      INT_EXTB:          r = {{(INT_WIDTH-8){a[7]}}, a[7:0]};
      INT_COM:           r = ~a;
      INT_NEG:           r = '0 - a;
      INT_DIV, INT_DIVU: r = '1;
      INT_MOD, INT_MODU: r = a;
      default:           r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bexkat1_intseq_if.sv
// Start/done request bus between the control unit and the integer sequencer.
interface bexkat1_intseq_if #(parameter int WIDTH = 32);
  import bexkat1Def::*;

  logic             start_i;
  intfunc_t         func_i;
  logic [WIDTH-1:0] in1_i;
  logic [WIDTH-1:0] in2_i;
  logic [WIDTH-1:0] out_o;
  logic             done_o;
  logic             busy_o;
  logic             divzero_o;

  modport master (
    output start_i, func_i, in1_i, in2_i,
    input  out_o, done_o, busy_o, divzero_o
  );

  modport slave (
    input  start_i, func_i, in1_i, in2_i,
    output out_o, done_o, busy_o, divzero_o
  );
endinterface

// File: rtl/bexkat1_intseq_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module bexkat1_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    fits    = (shifted >= {1'b0, divisor});
    if (fits) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bexkat1_intseq.sv
// Multi-cycle integer unit: 32-step shift-add multiply, 32-step restoring
// divide, single-step unary ops, start/done handshake with registered outputs.
module bexkat1_intseq
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  bexkat1_intseq_if.slave   bus
);

  intseq_state_t      state_reg;
  intfunc_t           func_reg;
  logic [4:0]         count_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   out_reg;
  logic               done_reg;
  logic               divzero_reg;

  logic               a_neg, b_neg, is_mul, is_div, is_signed, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, a_op, b_op;

  // Request decode; signed forms iterate on operand magnitudes
  always_comb begin
    is_mul    = bus.func_i inside {INT_MUL, INT_MULU, INT_MULX, INT_MULUX};
    is_div    = bus.func_i inside {INT_DIV, INT_MOD, INT_DIVU, INT_MODU};
    is_signed = bus.func_i inside {INT_MUL, INT_MULX, INT_DIV, INT_MOD};
    b_zero    = (bus.in2_i == '0);
    a_neg     = bus.in1_i[WIDTH-1];
    b_neg     = bus.in2_i[WIDTH-1];
    a_mag     = a_neg ? ('0 - bus.in1_i) : bus.in1_i;
    b_mag     = b_neg ? ('0 - bus.in2_i) : bus.in2_i;
    a_op      = is_signed ? a_mag : bus.in1_i;
    b_op      = is_signed ? b_mag : bus.in2_i;
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_result;

  // Low half holds the unconsumed multiplier bits, high half the running sum
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
               (acc_reg[0] ? {1'b0, b_reg} : '0);
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    prod     = neg_q_reg ? ('0 - mul_next) : mul_next;
    if (func_reg inside {INT_MULX, INT_MULUX})
      mul_result = prod[2*WIDTH-1:WIDTH];
    else
      mul_result = prod[WIDTH-1:0];
  end

  logic [WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix, div_result;

  bexkat1_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc_reg[2*WIDTH-1:WIDTH]),
    .quo      (acc_reg[WIDTH-1:0]),
    .divisor  (b_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    quo_fix    = neg_q_reg ? ('0 - quo_next) : quo_next;
    rem_fix    = neg_r_reg ? ('0 - rem_next) : rem_next;
    div_result = (func_reg inside {INT_DIV, INT_DIVU}) ? quo_fix : rem_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IS_IDLE;
      func_reg    <= INT_MUL;
      count_reg   <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      out_reg     <= '0;
      done_reg    <= 1'b0;
      divzero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IS_IDLE: begin
          if (bus.start_i) begin
            func_reg  <= bus.func_i;
            b_reg     <= b_op;
            acc_reg   <= {{WIDTH{1'b0}}, a_op};
            neg_q_reg <= is_signed && (a_neg != b_neg);
            neg_r_reg <= is_signed && a_neg;
            if (is_mul || (is_div && !b_zero)) begin
              state_reg <= is_mul ? IS_MUL : IS_DIV;
              count_reg <= 5'd31;
            end else begin
              state_reg   <= IS_DONE;
              out_reg     <= immediate_result(bus.func_i, bus.in1_i);
              divzero_reg <= is_div;
              done_reg    <= 1'b1;
            end
          end
        end
        IS_MUL, IS_DIV: begin
          acc_reg   <= (state_reg == IS_MUL) ? mul_next : {rem_next, quo_next};
          count_reg <= count_reg - 5'd1;
          // Sign fix-up and result select happen on the exit edge itself
          if (count_reg == 5'd0) begin
            state_reg   <= IS_DONE;
            count_reg   <= 5'd0;
            out_reg     <= (state_reg == IS_MUL) ? mul_result : div_result;
            divzero_reg <= 1'b0;
            done_reg    <= 1'b1;
          end
        end
        IS_DONE: state_reg <= IS_IDLE;
        default: state_reg <= IS_IDLE;
      endcase
    end
  end

  assign bus.out_o     = out_reg;
  assign bus.done_o    = done_reg;
  assign bus.busy_o    = (state_reg != IS_IDLE);
  assign bus.divzero_o = divzero_reg;

endmodule

// File: doc/bexkat1_intseq.md
# bexkat1_intseq

Multi-cycle integer execution unit for the bexkat1 core. It responds to the control unit's INT-class requests and returns the result the control unit latches through the MDR_INT mux path. It implements every `intfunc_t` operation. Multiply and divide/modulo run iteratively over 32 steps; the unary operations complete in one step. All handshaking is start/done, with no combinational path from the inputs to `done_o`.

## Interface
Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported; the parameter is kept for lint and elaboration checks.

Ports:
- clk_i, input, 1, sole clock. Everything is on the rising edge.
- rst_i, input, 1, reset. Synchronous, active-high.
- start_i, input, 1, request strobe. Sampled only in IDLE.
- func_i, input, intfunc_t (4 bits), operation select. Captured with `start_i`.
- in1_i, input, 32, operand A, from register A.
- in2_i, input, 32, operand B. The control unit has already selected this upstream via `int2_t` (INT2_B or INT2_SVAL).
- out_o, output, 32, result. Holds its value until the next `done_o`.
- done_o, output, 1, one-cycle pulse. `out_o` and `divzero_o` are valid in this cycle.
- busy_o, output, 1, high in every state except IDLE.
- divzero_o, output, 1, divisor was zero on a DIV/MOD/DIVU/MODU request. Valid with `done_o` and held with `out_o`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- From IDLE, on `start_i`, the unit latches `func_i`, `in1_i` and `in2_i` and moves as follows:
  - MUL/MULU/MULX/MULUX go to MUL.
  - DIV/MOD/DIVU/MODU with a nonzero divisor go to DIV.
  - All other cases go directly to DONE, with the result registered in that same edge.
- Multiply:
  - Shift-add over 32 steps, producing a 64-bit product of the operand magnitudes.
  - For the signed forms (MUL, MULX), the product is negated when the operand signs differ.
  - MUL and MULU return product[31:0].
  - MULX returns the signed product[63:32]. MULUX returns the unsigned product[63:32].
- Divide:
  - Restoring division over 32 steps on the magnitudes.
  - DIV negates the quotient when the operand signs differ.
  - MOD gives the remainder the sign of the dividend.
  - DIVU and MODU work on raw unsigned values.
  - 0x80000000 / -1 produces 0x80000000, with remainder 0. There is no trap.
- Divide by zero: no iteration, go straight to DONE with `divzero_o`=1.
  - DIV and DIVU return 0xFFFFFFFF.
  - MOD and MODU return `in1_i`.
- Unary operations:
  - EXT sign-extends in1[15:0].
  - EXTB sign-extends in1[7:0].
  - COM returns ~in1.
  - NEG returns 0 − in1.
- Unused codes 12–15 return 0 in one step, with `divzero_o`=0.
- A 5-bit step counter loads 31 on entry to MUL or DIV. The unit leaves for DONE when the counter reads 0 at an edge.
- The final sign fix-up is registered on that exit edge, not in DONE.
- DONE always returns to IDLE on the next edge.

## Timing
- Reset values: `out_o`=0, `done_o`=0, `busy_o`=0, `divzero_o`=0, state IDLE, counter 0.
- Latency, with `start_i` sampled at edge N:
  - Mul/div: 32 iteration edges, N+1 through N+32. `done_o` is high in the cycle after edge N+32, so latency is 33 cycles.
  - Unary, unused codes and divide-by-zero: `done_o` is high in the cycle after edge N, so latency is 1 cycle.
- Throughput: the next `start_i` is accepted in the cycle after `done_o`. Back-to-back mul/div requests are therefore 34 cycles apart.
- `start_i` while `busy_o`=1 is ignored. The in-flight operation is unaffected.
- `func_i`, `in1_i` and `in2_i` may change freely after the start edge, because the operands are latched.
- `rst_i` mid-operation aborts the operation: no `done_o` and no partial result. In the next cycle `busy_o`=0 and `out_o`=0.
- If `rst_i` and `start_i` are asserted together, reset wins and the request is dropped.

## Structure
- `intfunc_t`, `int2_t` and `REG_SP` remain in bexkat1Def.
- Add `intseq_state_t` {IS_IDLE, IS_MUL, IS_DIV, IS_DONE} to bexkat1Def so the control unit and the bench can reference it.
- One sub-module, `bexkat1_divstep`: combinational, one restoring step.
  - Inputs: remainder, quotient and divisor.
  - Outputs: the next remainder and quotient.
  - It is reused by the DIV state only.
- The multiply step is inline, as an add/shift on a 64-bit accumulator.

## Test plan
- MUL, MULX and MULUX with in1=7, in2=0xFFFFFFFD:
  - MUL: `out_o`=0xFFFFFFEB.
  - MULX: 0xFFFFFFFF.
  - MULUX: 0x00000006.
  - Each `done_o` lands exactly 33 cycles after start.
- DIV and MOD with in1=0xFFFFFFF9 (−7), in2=2:
  - DIV: 0xFFFFFFFD.
  - MOD: 0xFFFFFFFF.
  - DIVU on the same operands: 0x7FFFFFFC. MODU: 0x00000001.
- DIVU 5/0:
  - `done_o` one cycle after start, `out_o`=0xFFFFFFFF, `divzero_o`=1.
  - MODU 5/0 returns 5.
- DIV with 0x80000000 by 0xFFFFFFFF: result 0x80000000, MOD 0, `divzero_o`=0.
- Unary operations, each with `done_o` at 1 cycle:
  - EXTB 0x00000080 gives 0xFFFFFF80.
  - EXT 0x00007FFF gives 0x00007FFF.
  - NEG 1 gives 0xFFFFFFFF.
  - COM 0 gives 0xFFFFFFFF.
- Busy and reset behaviour:
  - Pulse `start_i` again with new operands during a busy MUL: it is ignored, and the original result is delivered.
  - Assert `rst_i` 10 cycles into a DIV: next cycle `busy_o`=0 and `out_o`=0, no `done_o` follows, and a fresh start completes normally.
